// File: rtl/sweep_counter_ctrl.sv
// sweep_counter_ctrl: drives an external up/down counter through repeated triangle sweeps.
// Optional macro SWEEP_DWELL_EN adds a DWELL hold at each turnaround.
module sweep_counter_ctrl #(
   parameter int N = 4,
   parameter int S = 4
`ifdef SWEEP_DWELL_EN
   , parameter int D = 8
`endif
) (
`ifdef SWEEP_DWELL_EN
   input  logic [D-1:0] dwell_cycles,
`endif
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [N-1:0] start_val,
   input  logic [N-1:0] high_lim,
   input  logic [N-1:0] low_lim,
   input  logic [S-1:0] num_sweeps,
   input  logic [N-1:0] cnt_value,
   input  logic         cnt_carry,
   output logic         cnt_load,
   output logic         cnt_up_down,
   output logic [N-1:0] cnt_load_value,
   output logic         busy,
   output logic         done,
   output logic         cfg_err,
   output logic         wrap_err
);
   typedef enum logic [2:0] {
      IDLE, LOAD, UP, DOWN, DONE, ERR
`ifdef SWEEP_DWELL_EN
      , DWELL
`endif
   } state_t;
   state_t state, nxt;
   logic [N-1:0] start_q, high_q, low_q;
   logic [S-1:0] num_q, sweep_cnt;
   logic valid, at_hi, at_lo, last;
`ifdef SWEEP_DWELL_EN
   logic [D-1:0] dwell_q, dwell_cnt;
   logic ret_down;
`endif
   assign valid = low_lim < high_lim && low_lim <= start_val && start_val <= high_lim && num_sweeps != '0;
   assign at_hi = cnt_value == high_q;
   assign at_lo = cnt_value == low_q;
   assign last  = sweep_cnt + 1'b1 == num_q;
   always_comb begin
      nxt = state;
      cnt_load = 1'b1;
      cnt_load_value = cnt_value;
      cnt_up_down = 1'b1;
      busy = state == LOAD || state == UP || state == DOWN;
      done = state == DONE;
`ifdef SWEEP_DWELL_EN
      busy = busy || state == DWELL;
`endif
      case (state)
         IDLE: nxt = start && valid ? LOAD : IDLE;
         LOAD: begin
            cnt_load_value = start_q;
            nxt = UP;
         end
         UP: begin
            cnt_load = 1'b0;
            cnt_up_down = !at_hi;
            nxt = at_hi ? DOWN : UP;
`ifdef SWEEP_DWELL_EN
            if (at_hi && dwell_q != '0) begin
               cnt_load = 1'b1;
               nxt = DWELL;
            end
`endif
         end
         DOWN: begin
            cnt_load = at_lo && last;
            cnt_load_value = low_q;
            cnt_up_down = at_lo;
            nxt = at_lo ? (last ? DONE : UP) : DOWN;
`ifdef SWEEP_DWELL_EN
            if (at_lo && !last && dwell_q != '0) begin
               cnt_load = 1'b1;
               nxt = DWELL;
            end
`endif
         end
         DONE: nxt = IDLE;
         ERR:  nxt = start ? IDLE : ERR;
`ifdef SWEEP_DWELL_EN
         DWELL: nxt = dwell_cnt == 1 ? (ret_down ? DOWN : UP) : DWELL;
`endif
         default: nxt = IDLE;
      endcase
      // a wrap inside the sweep window means the counter and controller disagree
      if ((state == UP || state == DOWN) && cnt_carry) nxt = ERR;
      if (abort && busy) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         start_q <= '0;
         high_q <= '0;
         low_q <= '0;
         num_q <= '0;
         sweep_cnt <= '0;
         cfg_err <= 1'b0;
         wrap_err <= 1'b0;
      end else begin
         state <= nxt;
         cfg_err <= state == IDLE && start && !valid;
         if (state == IDLE && nxt == LOAD) begin
            start_q <= start_val;
            high_q <= high_lim;
            low_q <= low_lim;
            num_q <= num_sweeps;
            sweep_cnt <= '0;
            wrap_err <= 1'b0;
         end
         if (nxt == ERR) wrap_err <= 1'b1;
         if (state == DOWN && at_lo) sweep_cnt <= sweep_cnt + 1'b1;
      end
   end
`ifdef SWEEP_DWELL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_q <= '0;
         dwell_cnt <= '0;
         ret_down <= 1'b0;
      end else begin
         if (state == IDLE && nxt == LOAD) dwell_q <= dwell_cycles;
         if (nxt == DWELL && state != DWELL) begin
            dwell_cnt <= dwell_q;
            ret_down <= state == UP;
         end else if (state == DWELL) dwell_cnt <= dwell_cnt - 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// tb_sweep_counter_ctrl: directed and randomized sweeps against an attached counter model
// and an expected-trajectory reference built from the sweep rules.
module tb_sweep_counter_ctrl;
   localparam int N = 4;
   localparam int S = 4;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cnt_carry = 1'b0;
   logic [N-1:0] start_val = '0, high_lim = '0, low_lim = '0;
   logic [N-1:0] cnt_value = 4'd9;
   logic [S-1:0] num_sweeps = '0;
   logic cnt_load, cnt_up_down, busy, done, cfg_err, wrap_err;
   logic [N-1:0] cnt_load_value;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   sweep_counter_ctrl #(.N(N), .S(S)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .start_val(start_val), .high_lim(high_lim), .low_lim(low_lim), .num_sweeps(num_sweeps),
      .cnt_value(cnt_value), .cnt_carry(cnt_carry),
      .cnt_load(cnt_load), .cnt_up_down(cnt_up_down), .cnt_load_value(cnt_load_value),
      .busy(busy), .done(done), .cfg_err(cfg_err), .wrap_err(wrap_err)
   );

   // the external counter: loads, else counts every cycle
   always @(posedge clk)
      cnt_value <= cnt_load ? cnt_load_value : (cnt_up_down ? cnt_value + 1'b1 : cnt_value - 1'b1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   task automatic scramble_cfg();
      start_val = N'($urandom);
      high_lim = N'($urandom);
      low_lim = N'($urandom);
      num_sweeps = S'($urandom);
   endtask

   function automatic bit cfg_ok(int sv, int hi, int lo, int ns);
      return lo < hi && lo <= sv && sv <= hi && ns != 0;
   endfunction

   // ab/cy: trajectory index at which abort / carry is raised (-1 = never)
   task automatic run(input int sv, input int hi, input int lo, input int ns, input int ab, input int cy);
      int q[$];
      q = {};
      for (int v = sv; v <= hi; v++) q.push_back(v);
      for (int s = 0; s < ns; s++) begin
         if (s > 0) for (int v = lo + 1; v <= hi; v++) q.push_back(v);
         for (int v = hi - 1; v >= lo; v--) q.push_back(v);
      end
      start_val = N'(sv); high_lim = N'(hi); low_lim = N'(lo); num_sweeps = S'(ns);
      start = 1'b1;
      @(negedge clk);
      chk("load_busy", busy, 1);
      chk("load_wrap_clr", wrap_err, 0);
      start = 1'b0;
      scramble_cfg();
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         chk("sweep_cnt", cnt_value, q[i]);
         chk("sweep_busy", busy, 1);
         chk("sweep_done", done, 0);
         start = 1'($urandom);
         scramble_cfg();
         if (i == ab || i == cy) begin
            start = 1'b0;
            if (i == ab) abort = 1'b1;
            else cnt_carry = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            cnt_carry = 1'b0;
            chk("halt_busy", busy, 0);
            chk("halt_cnt", cnt_value, q[i+1]);
            chk("halt_wrap", wrap_err, i == cy);
            chk("halt_load", cnt_load, 1);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("halt_hold", cnt_value, q[i+1]);
               chk("halt_nodone", done, 0);
               chk("halt_wrap_sticky", wrap_err, i == cy);
            end
            return;
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_cnt", cnt_value, lo);
      @(negedge clk);
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("after_cnt", cnt_value, lo);
      chk("after_load", cnt_load, 1);
   endtask

   task automatic cfg_bad(input int sv, input int hi, input int lo, input int ns);
      logic [N-1:0] prev;
      prev = cnt_value;
      start_val = N'(sv); high_lim = N'(hi); low_lim = N'(lo); num_sweeps = S'(ns);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_busy", busy, 0);
      chk("cfg_cnt", cnt_value, prev);
      @(negedge clk);
      chk("cfg_err_end", cfg_err, 0);
      chk("cfg_cnt_hold", cnt_value, prev);
   endtask

   initial begin
      int lo, hi, sv, ns;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_wrap", wrap_err, 0);
      chk("rst_updown", cnt_up_down, 1);
      chk("rst_load", cnt_load, 1);
      chk("rst_hold_val", cnt_load_value, 9);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold", cnt_value, 9);

      run(2, 5, 1, 1, -1, -1);
      run(0, 3, 0, 3, -1, -1);
      cfg_bad(4, 4, 4, 1);
      cfg_bad(7, 5, 1, 1);
      cfg_bad(2, 5, 1, 0);
      run(2, 6, 1, 2, 6, -1);
      run(5, 5, 2, 2, -1, -1);

      run(1, 7, 0, 1, -1, 2);
      start_val = 4'd1; high_lim = 4'd3; low_lim = 4'd0; num_sweeps = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_exit_busy", busy, 0);
      chk("err_exit_wrap", wrap_err, 1);
      run(1, 3, 0, 1, -1, -1);

      start_val = 4'd1; high_lim = 4'd6; low_lim = 4'd0; num_sweeps = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20 && cnt_value != 4'd3; k++) @(negedge clk);
      chk("rst_reach3", cnt_value, 3);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_load", cnt_load, 1);
      chk("midrst_val", cnt_load_value, 3);
      chk("midrst_wrap", wrap_err, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_hold", cnt_value, 3);

      for (int t = 0; t < 8; t++) begin
         lo = $urandom_range(13, 0);
         hi = $urandom_range(15, lo + 1);
         sv = $urandom_range(hi, lo);
         ns = $urandom_range(3, 1);
         if (t % 3 == 2) begin
            sv = $urandom_range(15, 0);
            hi = $urandom_range(15, 0);
            lo = $urandom_range(15, 0);
            ns = $urandom_range(2, 0);
         end
         if (cfg_ok(sv, hi, lo, ns)) run(sv, hi, lo, ns, -1, -1);
         else cfg_bad(sv, hi, lo, ns);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running required finished");
      $fatal(1, "timeout");
   end
endmodule
